// File: rtl/chunked_seq_adder_if.sv
// chunked_seq_adder_if: operand/result handshake bundle for chunked_seq_adder
interface chunked_seq_adder_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: WIDTH-bit adder computed CHUNK bits per cycle with a registered ripple carry
module chunked_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst,
  chunked_seq_adder_if.slave bus_io
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_param_check
    $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CHUNK-1:0] sa, sb, s;
  logic c, last;
  int base;
  always_comb begin
    base = int'(idx_q) * CHUNK;
    sa = a_q[base +: CHUNK];
    sb = b_q[base +: CHUNK];
    {c, s} = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, carry_q};
    last = idx_q == IW'(NCHUNK - 1);
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (bus_io.in_valid) begin
        a_d = bus_io.a;
        b_d = bus_io.b;
        carry_d = bus_io.cin;
        idx_d = '0;
        state_d = ADD;
      end
      ADD: begin
        sum_d[base +: CHUNK] = s;
        carry_d = c;
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) begin
          cout_d = c;
          // carry into the MSB is recovered from the MSB sum bit and its two operand bits
          ovf_d = s[CHUNK-1] ^ sa[CHUNK-1] ^ sb[CHUNK-1] ^ c;
          state_d = HOLD;
        end
      end
      HOLD: state_d = bus_io.out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus_io.in_ready = (state_q == IDLE) && !rst;
  assign bus_io.out_valid = state_q == HOLD;
  assign bus_io.sum = sum_q;
  assign bus_io.cout = cout_q;
  assign bus_io.ovf = ovf_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb_chunked_seq_adder: directed checks of four chunked_seq_adder configurations
module tb_chunked_seq_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  // index 0: 16/4, 1: 32/8, 2: 8/8, 3: 8/1
  logic [31:0] av[4], bv[4], smv[4];
  logic cv[4], iv[4], orv[4], irv[4], ovv[4], cov[4], ofv[4];
  chunked_seq_adder_if #(.WIDTH(16)) i0();
  chunked_seq_adder_if #(.WIDTH(32)) i1();
  chunked_seq_adder_if #(.WIDTH(8)) i2();
  chunked_seq_adder_if #(.WIDTH(8)) i3();
  assign i0.a = av[0][15:0];
  assign i0.b = bv[0][15:0];
  assign i0.cin = cv[0];
  assign i0.in_valid = iv[0];
  assign i0.out_ready = orv[0];
  assign irv[0] = i0.in_ready;
  assign ovv[0] = i0.out_valid;
  assign smv[0] = {16'b0, i0.sum};
  assign cov[0] = i0.cout;
  assign ofv[0] = i0.ovf;
  assign i1.a = av[1];
  assign i1.b = bv[1];
  assign i1.cin = cv[1];
  assign i1.in_valid = iv[1];
  assign i1.out_ready = orv[1];
  assign irv[1] = i1.in_ready;
  assign ovv[1] = i1.out_valid;
  assign smv[1] = i1.sum;
  assign cov[1] = i1.cout;
  assign ofv[1] = i1.ovf;
  assign i2.a = av[2][7:0];
  assign i2.b = bv[2][7:0];
  assign i2.cin = cv[2];
  assign i2.in_valid = iv[2];
  assign i2.out_ready = orv[2];
  assign irv[2] = i2.in_ready;
  assign ovv[2] = i2.out_valid;
  assign smv[2] = {24'b0, i2.sum};
  assign cov[2] = i2.cout;
  assign ofv[2] = i2.ovf;
  assign i3.a = av[3][7:0];
  assign i3.b = bv[3][7:0];
  assign i3.cin = cv[3];
  assign i3.in_valid = iv[3];
  assign i3.out_ready = orv[3];
  assign irv[3] = i3.in_ready;
  assign ovv[3] = i3.out_valid;
  assign smv[3] = {24'b0, i3.sum};
  assign cov[3] = i3.cout;
  assign ofv[3] = i3.ovf;
  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .rst(rst), .bus_io(i0));
  chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u1 (.clk(clk), .rst(rst), .bus_io(i1));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) u2 (.clk(clk), .rst(rst), .bus_io(i2));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(1)) u3 (.clk(clk), .rst(rst), .bus_io(i3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic run(input int s, input logic [31:0] a, input logic [31:0] b, input logic c,
                     input int lat, input int hold, input string tag,
                     input logic [31:0] es, input logic ec, input logic eo);
    int n;
    av[s] = a;
    bv[s] = b;
    cv[s] = c;
    iv[s] = 1'b1;
    orv[s] = (hold == 0);
    chk({tag, " in_ready"}, 32'(irv[s]), 32'd1);
    tick;
    iv[s] = 1'b0;
    n = 0;
    while (!ovv[s] && n < 50) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " sum"}, smv[s], es);
    chk({tag, " cout"}, 32'(cov[s]), 32'(ec));
    chk({tag, " ovf"}, 32'(ofv[s]), 32'(eo));
    for (int k = 0; k < hold; k++) begin
      av[s] = ~a;
      bv[s] = a ^ 32'h5a5a_5a5a;
      iv[s] = 1'b1;
      tick;
      chk({tag, " hold valid"}, 32'(ovv[s]), 32'd1);
      chk({tag, " hold sum"}, smv[s], es);
      chk({tag, " hold in_ready"}, 32'(irv[s]), 32'd0);
    end
    iv[s] = 1'b0;
    orv[s] = 1'b1;
    tick;
    chk({tag, " released"}, 32'(ovv[s]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] r;
    for (int i = 0; i < 4; i++) begin
      av[i] = '0;
      bv[i] = '0;
      cv[i] = 1'b0;
      iv[i] = 1'b0;
      orv[i] = 1'b1;
    end
    rst = 1'b1;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst in_ready%0d", i), 32'(irv[i]), 32'd0);
      chk($sformatf("rst out_valid%0d", i), 32'(ovv[i]), 32'd0);
      chk($sformatf("rst sum%0d", i), smv[i], 32'd0);
      chk($sformatf("rst cout%0d", i), 32'(cov[i]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("post-rst in_ready%0d", i), 32'(irv[i]), 32'd1);
    run(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 4, 0, "ripple", 32'h0000_0000, 1'b1, 1'b0);
    run(0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 4, 0, "ovf pos", 32'h0000_8000, 1'b0, 1'b1);
    run(0, 32'h0000_8000, 32'h0000_8000, 1'b0, 4, 0, "ovf neg", 32'h0000_0000, 1'b1, 1'b1);
    run(1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 4, 10, "backpressure", 32'h2222_2222, 1'b0, 1'b0);
    av[1] = 32'h1111_1111;
    bv[1] = 32'h2222_2222;
    cv[1] = 1'b0;
    iv[1] = 1'b1;
    tick;
    iv[1] = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("midrst out_valid", 32'(ovv[1]), 32'd0);
    chk("midrst sum", smv[1], 32'd0);
    chk("midrst in_ready", 32'(irv[1]), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst in_ready after", 32'(irv[1]), 32'd1);
    run(1, 32'd1, 32'd1, 1'b0, 4, 0, "fresh", 32'd2, 1'b0, 1'b0);
    iv[2] = 1'b1;
    orv[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      av[2] = {24'b0, ra};
      bv[2] = {24'b0, rb};
      cv[2] = rc;
      r = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      chk("b2b in_ready", 32'(irv[2]), 32'd1);
      tick;
      chk("b2b early valid", 32'(ovv[2]), 32'd0);
      chk("b2b busy", 32'(irv[2]), 32'd0);
      tick;
      chk("b2b valid", 32'(ovv[2]), 32'd1);
      chk("b2b hold ready", 32'(irv[2]), 32'd0);
      chk("b2b sum", smv[2], {24'b0, r[7:0]});
      chk("b2b cout", 32'(cov[2]), 32'(r[8]));
      chk("b2b ovf", 32'(ofv[2]), 32'((ra[7] == rb[7]) && (r[7] != ra[7])));
      tick;
    end
    iv[2] = 1'b0;
    run(3, 32'h0000_00AA, 32'h0000_0055, 1'b1, 8, 0, "chunk1", 32'h0000_0000, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
